// File: rtl/tx_pkg.sv
// -----------------------------------------------------------------------------
// tx_pkg
// Shared types and constants for the transmission (1/t) sequencer slice.
//   tx_state_e   : sequencer state encoding (INIT, READY, RUN, DRAIN)
//   LUT_AW/DW    : reciprocal LUT address / data width
//   TINV_W       : width of the datapath one_by_t result
//   RECIP_NUM    : numerator of the reciprocal table, floor(RECIP_NUM/(a+1))
//   DIV_QW/DW    : serial divider quotient / divisor widths
//   recip_sat()  : clamps a 13-bit quotient into the 12-bit LUT word
// -----------------------------------------------------------------------------
package tx_pkg;

   typedef enum logic [1:0] {
      INIT  = 2'd0,
      READY = 2'd1,
      RUN   = 2'd2,
      DRAIN = 2'd3
   } tx_state_e;

   localparam int LUT_AW      = 8;
   localparam int LUT_DW      = 12;
   localparam int LUT_ENTRIES = 1 << LUT_AW;
   localparam int TINV_W      = 11;
   localparam int RECIP_NUM   = 4096;
   localparam int RECIP_MAX   = (1 << LUT_DW) - 1;
   localparam int DIV_QW      = 13;
   localparam int DIV_DW      = 9;

   // Only a=0 yields 4096, which does not fit the 12-bit table word.
   function automatic logic [LUT_DW-1:0] recip_sat(input logic [DIV_QW-1:0] q);
      return (q > DIV_QW'(RECIP_MAX)) ? {LUT_DW{1'b1}} : q[LUT_DW-1:0];
   endfunction

endpackage

// File: rtl/tx_lut_sequencer_if.sv
// -----------------------------------------------------------------------------
// tx_lut_sequencer_if
// Handshake bundle around the sequencer.
//   s_valid / s_ready : pixel admission from the dark-channel stage
//   m_valid / m_ready : result hand-off to the radiance-recovery stage
//   m_data            : one_by_t result at the head of the result FIFO
// Modports:
//   slave  : the sequencer (accepts pixels, sources results)
//   master : the surrounding environment (offers pixels, sinks results)
// -----------------------------------------------------------------------------
interface tx_lut_sequencer_if;
   import tx_pkg::*;

   logic              s_valid;
   logic              s_ready;
   logic              m_valid;
   logic              m_ready;
   logic [TINV_W-1:0] m_data;

   modport slave (
      input  s_valid,
      input  m_ready,
      output s_ready,
      output m_valid,
      output m_data
   );

   modport master (
      output s_valid,
      output m_ready,
      input  s_ready,
      input  m_valid,
      input  m_data
   );

endinterface

// File: rtl/recip_div_serial.sv
// -----------------------------------------------------------------------------
// recip_div_serial
// Restoring serial divider, one quotient bit per cycle, DIV_QW cycles total.
// The i_start cycle already performs the first iteration, so the quotient is
// complete after DIV_QW clocks and o_done pulses on the following cycle.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_start        : begin a division (operands sampled this cycle)
//   i_dividend     : DIV_QW-bit dividend
//   i_divisor      : DIV_DW-bit non-zero divisor
//   o_busy         : iterations still pending
//   o_done         : one-cycle pulse, o_quot valid (held until next start)
//   o_quot         : DIV_QW-bit quotient
// -----------------------------------------------------------------------------
module recip_div_serial
   import tx_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic [DIV_QW-1:0] i_dividend,
   input  logic [DIV_DW-1:0] i_divisor,
   output logic              o_busy,
   output logic              o_done,
   output logic [DIV_QW-1:0] o_quot
);

   localparam int CNT_W = $clog2(DIV_QW) + 1;

   logic              busy_q;
   logic              done_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [DIV_DW-1:0] rem_q;
   logic [DIV_DW-1:0] dvs_q;
   logic [DIV_QW-1:0] quot_q;

   logic [DIV_DW-1:0] rem_cur;
   logic [DIV_DW-1:0] dvs_cur;
   logic [DIV_QW-1:0] quot_cur;
   logic [DIV_DW:0]   rem_sh;
   logic [DIV_DW-1:0] rem_d;
   logic [DIV_QW-1:0] quot_d;

   // One restoring step. On start the fresh operands feed the step directly.
   // Remainder stays below the divisor (<= 256), so 9 bits hold it and the
   // 9-bit modular subtraction below is exact.
   always_comb begin
      rem_cur  = i_start ? '0         : rem_q;
      quot_cur = i_start ? i_dividend : quot_q;
      dvs_cur  = i_start ? i_divisor  : dvs_q;
      rem_sh   = {rem_cur, quot_cur[DIV_QW-1]};
      rem_d    = rem_sh[DIV_DW-1:0];
      quot_d   = {quot_cur[DIV_QW-2:0], 1'b0};
      if (rem_sh >= {1'b0, dvs_cur}) begin
         rem_d     = rem_sh[DIV_DW-1:0] - dvs_cur;
         quot_d[0] = 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
         cnt_q  <= '0;
         rem_q  <= '0;
         dvs_q  <= '0;
         quot_q <= '0;
      end else begin
         done_q <= 1'b0;
         if (i_start) begin
            busy_q <= 1'b1;
            cnt_q  <= CNT_W'(DIV_QW - 1);
            rem_q  <= rem_d;
            quot_q <= quot_d;
            dvs_q  <= i_divisor;
         end else if (busy_q) begin
            rem_q  <= rem_d;
            quot_q <= quot_d;
            cnt_q  <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign o_busy = busy_q;
   assign o_done = done_q;
   assign o_quot = quot_q;

endmodule

// File: rtl/tx_lut_sequencer.sv
// -----------------------------------------------------------------------------
// tx_lut_sequencer
// Controller for the 1/t datapath. After reset it fills the 256-entry
// reciprocal LUTs with floor(4096/(a+1)) (saturated to 4095), then admits one
// frame of pixels into the fixed-latency datapath under credit control and
// buffers the one_by_t results so a downstream stall never loses one.
// Ports:
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_start          : begin a frame (READY only)
//   i_reload         : rebuild the LUT (READY only, beats i_start)
//   o_lut_we/addr/din: shared write bus to the R/G/B LUT RAMs
//   o_lut_ready      : LUT contents valid
//   bus              : pixel (s_*) and result (m_*) handshakes
//   o_dp_issue       : datapath input register enable (= accepted pixel)
//   i_dp_tinv        : datapath result, valid PIPE_LAT cycles after issue
//   o_busy           : not in READY
//   o_done           : one-cycle pulse when the frame has fully drained
// -----------------------------------------------------------------------------
module tx_lut_sequencer
   import tx_pkg::*;
#(
   parameter int PIPE_LAT     = 4,
   parameter int FIFO_DEPTH   = 8,
   parameter int FRAME_PIXELS = 307200
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_start,
   input  logic                i_reload,
   output logic                o_lut_we,
   output logic [LUT_AW-1:0]   o_lut_addr,
   output logic [LUT_DW-1:0]   o_lut_din,
   output logic                o_lut_ready,
   tx_lut_sequencer_if.slave   bus,
   output logic                o_dp_issue,
   input  logic [TINV_W-1:0]   i_dp_tinv,
   output logic                o_busy,
   output logic                o_done
);

   localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW  = $clog2(FIFO_DEPTH) + 1;
   localparam int PCW = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;

   tx_state_e         state_q, state_d;
   logic [LUT_AW-1:0] addr_q, addr_d;
   logic [PCW-1:0]    pix_q, pix_d;
   logic [PIPE_LAT-1:0] vld_q, vld_d;

   logic [TINV_W-1:0] fifo_mem_q [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     fifo_cnt_q, fifo_cnt_d;
   logic [CW-1:0]     inflight;

   logic              div_start;
   logic              div_busy;
   logic              div_done;
   logic [DIV_QW-1:0] div_quot;
   logic [DIV_DW-1:0] divisor;

   logic s_ready, issue, push, pop, m_valid, credit_ok, lut_we, done;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // ---------------------------------------------------------------- divider
   assign divisor = DIV_DW'(addr_q) + DIV_DW'(1);

   recip_div_serial u_div (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_start    (div_start),
      .i_dividend (DIV_QW'(RECIP_NUM)),
      .i_divisor  (divisor),
      .o_busy     (div_busy),
      .o_done     (div_done),
      .o_quot     (div_quot)
   );

   // ---------------------------------------------------------------- credits
   // Every issued pixel holds a credit until it leaves the FIFO, so the tail
   // of the valid shift register can never push into a full FIFO.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
         inflight = inflight + CW'(vld_q[i]);
      end
   end

   assign credit_ok = ({1'b0, inflight} + {1'b0, fifo_cnt_q}) < (CW+1)'(FIFO_DEPTH);
   assign s_ready   = (state_q == RUN) && credit_ok;
   assign issue     = bus.s_valid && s_ready;

   assign vld_d[0] = issue;
   for (genvar gi = 1; gi < PIPE_LAT; gi++) begin : g_vld
      assign vld_d[gi] = vld_q[gi-1];
   end

   // ---------------------------------------------------------------- FIFO
   assign push    = vld_q[PIPE_LAT-1];
   assign m_valid = (fifo_cnt_q != '0);
   assign pop     = m_valid && bus.m_ready;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      fifo_cnt_d = fifo_cnt_q;
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
         2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
         2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
         default: fifo_cnt_d = fifo_cnt_q;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (push) fifo_mem_q[wr_ptr_q] <= i_dp_tinv;
   end

   // ---------------------------------------------------------------- FSM
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      pix_d     = pix_q;
      div_start = 1'b0;
      lut_we    = 1'b0;
      done      = 1'b0;
      case (state_q)
         INIT: begin
            // Each entry: 13 divide cycles, then one write cycle.
            div_start = !div_busy && !div_done;
            if (div_done) begin
               lut_we = 1'b1;
               addr_d = addr_q + LUT_AW'(1);
               if (addr_q == LUT_AW'(LUT_ENTRIES - 1)) state_d = READY;
            end
         end
         READY: begin
            if (i_reload) begin
               state_d = INIT;
               addr_d  = '0;
            end else if (i_start) begin
               state_d = RUN;
               pix_d   = '0;
            end
         end
         RUN: begin
            if (issue) begin
               pix_d = pix_q + PCW'(1);
               if (pix_q == PCW'(FRAME_PIXELS - 1)) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if ((inflight == '0) && (fifo_cnt_q == '0)) begin
               state_d = READY;
               done    = 1'b1;
            end
         end
         default: state_d = INIT;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= INIT;
         addr_q     <= '0;
         pix_q      <= '0;
         vld_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         pix_q      <= pix_d;
         vld_q      <= vld_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fifo_cnt_q <= fifo_cnt_d;
      end
   end

   // ---------------------------------------------------------------- outputs
   assign o_lut_we    = lut_we;
   assign o_lut_addr  = addr_q;
   assign o_lut_din   = recip_sat(div_quot);
   assign o_lut_ready = (state_q != INIT);
   assign o_dp_issue  = issue;
   assign o_busy      = (state_q != READY);
   assign o_done      = done;

   assign bus.s_ready = s_ready;
   assign bus.m_valid = m_valid;
   // Gated so the bus reads zero while empty (storage is not reset).
   assign bus.m_data  = m_valid ? fifo_mem_q[rd_ptr_q] : '0;

endmodule
